// File: rtl/mux_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mux_ctrl_pkg
// Shared types and constants for the 16-to-8 mux sequencing controller.
//   mux_ctrl_state_t : controller FSM state encoding (IDLE / SETTLE / PRESENT)
//   SEL_BANK0/1      : mux select values for source bank 0 (D0) and bank 1 (D1)
//   STAT_W           : width of the optional statistics counters
//   stat_inc()       : saturating increment for the statistics counters
// Optional build macro affecting users of this package: MUX16TO8_CTRL_STATS_EN
// ---------------------------------------------------------------------------
package mux_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2
  } mux_ctrl_state_t;

  localparam logic SEL_BANK0 = 1'b0;
  localparam logic SEL_BANK1 = 1'b1;

  localparam int STAT_W = 16;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mux_settle_timer.sv
// ---------------------------------------------------------------------------
// mux_settle_timer
// Counts the settle window after a mux select toggle.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   load_i : a select toggle is being committed this cycle; start a new window
//   dec_i  : window in progress; count down
//   done_o : window complete. With SETTLE_CYC=0 it is asserted on load so the
//            controller can skip the settle state entirely.
// ---------------------------------------------------------------------------
module mux_settle_timer
  import mux_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);

  localparam int CW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  // The first settle cycle is the one following the load, so the window
  // ends when the counter reaches zero after SETTLE_CYC-1 decrements.
  localparam logic [CW-1:0] LOAD_VAL = (SETTLE_CYC > 0) ? CW'(SETTLE_CYC - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = load_i ? (SETTLE_CYC == 0) : (cnt_q == '0);

endmodule

// File: rtl/mux16to8_sel_ctrl.sv
// ---------------------------------------------------------------------------
// mux16to8_sel_ctrl
// Sequencing controller for the 16-to-8 selection mux. Arbitrates two source
// banks onto the shared mux, holds sel stable for SETTLE_CYC cycles after a
// toggle, then offers the result downstream with a valid/ready handshake.
//   clk           : clock, rising edge
//   rst           : synchronous active-high reset
//   req_valid[1:0]: bank i has data on its mux inputs
//   req_ready[1:0]: one-hot transfer strobe back to bank i
//   sel           : registered mux select (0 = bank 0, 1 = bank 1)
//   out_valid     : mux output settled and valid
//   out_ready     : consumer accepts
//   out_src       : bank currently presented (same as sel)
//   stat_xfers    : saturating transfer count       (MUX16TO8_CTRL_STATS_EN)
//   stat_switches : saturating select toggle count  (MUX16TO8_CTRL_STATS_EN)
// Build option: define MUX16TO8_CTRL_STATS_EN to add the statistics outputs.
// ---------------------------------------------------------------------------
module mux16to8_sel_ctrl
  import mux_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int HOLD_MAX   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  output logic       sel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_src
`ifdef MUX16TO8_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_xfers,
  output logic [STAT_W-1:0] stat_switches
`endif
);

  localparam int BW = $clog2(HOLD_MAX + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(HOLD_MAX);

  mux_ctrl_state_t state_q, state_d;
  logic            sel_q, sel_d;
  logic [BW-1:0]   burst_q, burst_d, burst_sat;

  logic cur_v, oth_v;
  logic xfer;
  logic arb_en, arb_stay, arb_switch;
  logic settle_done;

  assign cur_v = req_valid[sel_q];
  assign oth_v = req_valid[~sel_q];

  // Burst count including the transfer happening this cycle; arbitration
  // must see it so that the HOLD_MAX-th transfer already yields the bank.
  assign burst_sat = (xfer && (burst_q != BURST_MAX)) ? burst_q + 1'b1 : burst_q;

  // Arbitration points: IDLE, and PRESENT on a transfer or when the
  // presented bank drops its request without one.
  assign arb_en     = (state_q == IDLE) ||
                      ((state_q == PRESENT) && (xfer || !cur_v));
  assign arb_stay   = cur_v && ((burst_sat < BURST_MAX) || !oth_v);
  assign arb_switch = arb_en && !arb_stay && oth_v;

  mux_settle_timer #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_settle (
    .clk    (clk),
    .rst    (rst),
    .load_i (arb_switch),
    .dec_i  (state_q == SETTLE),
    .done_o (settle_done)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= SEL_BANK0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      burst_q <= burst_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    burst_d = burst_sat;
    unique case (state_q)
      IDLE, PRESENT: begin
        if (arb_en) begin
          if (arb_stay) begin
            state_d = PRESENT;
          end else if (arb_switch) begin
            sel_d   = ~sel_q;
            burst_d = '0;
            state_d = settle_done ? PRESENT : SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      SETTLE: begin
        if (settle_done) state_d = PRESENT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid = (state_q == PRESENT) && cur_v;
    xfer      = out_valid && out_ready;
    req_ready = 2'b00;
    if (xfer) begin
      req_ready = (sel_q == SEL_BANK1) ? 2'b10 : 2'b01;
    end
  end

  assign sel     = sel_q;
  assign out_src = sel_q;

`ifdef MUX16TO8_CTRL_STATS_EN
  logic [STAT_W-1:0] xfers_q, switches_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      xfers_q    <= '0;
      switches_q <= '0;
    end else begin
      if (xfer)       xfers_q    <= stat_inc(xfers_q);
      if (arb_switch) switches_q <= stat_inc(switches_q);
    end
  end

  assign stat_xfers    = xfers_q;
  assign stat_switches = switches_q;
`endif

endmodule

// File: tb/tb_mux16to8_sel_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mux16to8_sel_ctrl
// Directed bench for mux16to8_sel_ctrl. u_dut uses the default parameters
// (SETTLE_CYC=2, HOLD_MAX=4); u_dut0 uses SETTLE_CYC=0 for the zero-settle
// cases and, when MUX16TO8_CTRL_STATS_EN is defined, the statistics outputs.
// Inputs change 1 time unit after a rising edge; outputs are sampled one
// further unit later, well before the next edge.
// ---------------------------------------------------------------------------
module tb_mux16to8_sel_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] rv, rr;
  logic       ordy, sel, ov, src;

  logic [1:0] rv0, rr0;
  logic       ordy0, sel0, ov0, src0;

`ifdef MUX16TO8_CTRL_STATS_EN
  logic [15:0] sx, ss, sx0, ss0;
`endif

  int n_total = 0;
  int n_pass  = 0;

  mux16to8_sel_ctrl #(
    .SETTLE_CYC (2),
    .HOLD_MAX   (4)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (rv),
    .req_ready (rr),
    .sel       (sel),
    .out_valid (ov),
    .out_ready (ordy),
    .out_src   (src)
`ifdef MUX16TO8_CTRL_STATS_EN
    ,
    .stat_xfers    (sx),
    .stat_switches (ss)
`endif
  );

  mux16to8_sel_ctrl #(
    .SETTLE_CYC (0),
    .HOLD_MAX   (4)
  ) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (rv0),
    .req_ready (rr0),
    .sel       (sel0),
    .out_valid (ov0),
    .out_ready (ordy0),
    .out_src   (src0)
`ifdef MUX16TO8_CTRL_STATS_EN
    ,
    .stat_xfers    (sx0),
    .stat_switches (ss0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 unit after the last reset edge with rst low, so the
  // caller's next input setting is "cycle 1" after reset.
  task automatic do_reset();
    rst   = 1'b1;
    rv    = 2'b00;
    ordy  = 1'b0;
    rv0   = 2'b00;
    ordy0 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_rr;
    logic       exp_sel;
    int         k;

    // ---------------- reset values and same-bank request ----------------
    rst   = 1'b1;
    rv    = 2'b00;
    ordy  = 1'b0;
    rv0   = 2'b00;
    ordy0 = 1'b0;
    tick();
    #1;
    check("rst_sel", sel, 1'b0);
    check("rst_out_valid", ov, 1'b0);
    check("rst_req_ready", rr, 2'b00);
    check("rst_out_src", src, 1'b0);
    do_reset();
    rv   = 2'b01;
    ordy = 1'b1;
    #1;
    check("c1_idle_out_valid", ov, 1'b0);
    check("c1_idle_req_ready", rr, 2'b00);
    tick();
    check("c2_sel", sel, 1'b0);
    check("c2_out_valid", ov, 1'b1);
    check("c2_req_ready", rr, 2'b01);
    tick();
    rv = 2'b00;
    #1;
    check("c3_drop_out_valid", ov, 1'b0);
    tick();
    check("c4_idle_req_ready", rr, 2'b00);

    // ---------------- switch from IDLE with settle window ----------------
    rv = 2'b10;
    #1;
    check("sw_n_out_valid", ov, 1'b0);
    check("sw_n_sel", sel, 1'b0);
    tick();
    check("sw_n1_sel", sel, 1'b1);
    check("sw_n1_out_valid", ov, 1'b0);
    check("sw_n1_req_ready", rr, 2'b00);
    tick();
    check("sw_n2_sel", sel, 1'b1);
    check("sw_n2_out_valid", ov, 1'b0);
    tick();
    check("sw_n3_out_valid", ov, 1'b1);
    check("sw_n3_req_ready", rr, 2'b10);
    check("sw_n3_out_src", src, 1'b1);
    tick();
    rv = 2'b00;

    // ---------------- both banks valid: 4 / settle 2 / 4 ----------------
    do_reset();
    rv   = 2'b11;
    ordy = 1'b1;
    #1;
    check("burst_c1_out_valid", ov, 1'b0);
    for (int c = 2; c < 26; c++) begin
      tick();
      k = (c - 2) % 12;
      if (k < 4) begin
        exp_rr = 2'b01; exp_sel = 1'b0;
      end else if (k < 6) begin
        exp_rr = 2'b00; exp_sel = 1'b1;
      end else if (k < 10) begin
        exp_rr = 2'b10; exp_sel = 1'b1;
      end else begin
        exp_rr = 2'b00; exp_sel = 1'b0;
      end
      check($sformatf("burst_c%0d_req_ready", c), rr, exp_rr);
      check($sformatf("burst_c%0d_sel", c), sel, exp_sel);
      check($sformatf("burst_c%0d_out_valid", c), ov, exp_rr != 2'b00);
    end

    // ---------------- consumer stall ----------------
    do_reset();
    rv   = 2'b01;
    ordy = 1'b0;
    for (int c = 2; c <= 6; c++) begin
      tick();
      check($sformatf("stall_c%0d_out_valid", c), ov, 1'b1);
      check($sformatf("stall_c%0d_sel", c), sel, 1'b0);
      check($sformatf("stall_c%0d_req_ready", c), rr, 2'b00);
    end
    tick();
    ordy = 1'b1;
    #1;
    check("stall_release_req_ready", rr, 2'b01);
    tick();
    rv   = 2'b00;
    ordy = 1'b0;
    #1;
    check("stall_after_req_ready", rr, 2'b00);
    check("stall_after_out_valid", ov, 1'b0);

    // ---------------- reset during SETTLE ----------------
    do_reset();
    rv   = 2'b10;
    ordy = 1'b1;
    tick();
    check("rs_settle_sel", sel, 1'b1);
    check("rs_settle_req_ready", rr, 2'b00);
    rst = 1'b1;
    #1;
    check("rs_assert_req_ready", rr, 2'b00);
    tick();
    rst = 1'b0;
    rv  = 2'b01;
    #1;
    check("rs_after_sel", sel, 1'b0);
    check("rs_after_out_valid", ov, 1'b0);
    check("rs_after_req_ready", rr, 2'b00);
    tick();
    check("rs_resume_out_valid", ov, 1'b1);
    check("rs_resume_req_ready", rr, 2'b01);
    rv = 2'b00;

    // ---------------- SETTLE_CYC = 0, alternating single requests ----------------
    do_reset();
    ordy0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_sel = i[0];
      exp_rr  = exp_sel ? 2'b10 : 2'b01;
      rv0     = exp_rr;
      #1;
      check($sformatf("z%0d_req_out_valid", i), ov0, 1'b0);
      tick();
      check($sformatf("z%0d_sel", i), sel0, exp_sel);
      check($sformatf("z%0d_out_src", i), src0, exp_sel);
      check($sformatf("z%0d_out_valid", i), ov0, 1'b1);
      check($sformatf("z%0d_req_ready", i), rr0, exp_rr);
      tick();
    end
    rv0 = 2'b00;
    tick();
`ifdef MUX16TO8_CTRL_STATS_EN
    check("z_stat_xfers", sx0, 16'd6);
    check("z_stat_switches", ss0, 16'd5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mux16to8_sel_ctrl.md
# mux16to8_sel_ctrl

Sequencing controller for the 16-to-8 selection mux. It shares the 8-lane mux datapath between two 8-bit source banks (bank 0 = D0 side, bank 1 = D1 side) and drives the mux `sel` line. It guarantees `sel` is stable for a programmable settle window before a result is offered downstream. The downstream side uses a valid/ready handshake. The block sits between the bank producers and the consumer of the mux output.

## Interface
Parameters:
- `SETTLE_CYC`, default 2: cycles waited after a `sel` toggle before output is presented; 0 is legal.
- `HOLD_MAX`, default 4: maximum consecutive transfers from one bank while the other bank is waiting; must be ≥1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  2  bank i has data on its mux inputs; held until its `req_ready[i]`.
- `req_ready`  out  2  one-hot transfer strobe to bank i.
- `sel`  out  1  mux select; 0 = bank 0, 1 = bank 1; registered.
- `out_valid`  out  1  mux output is settled and holds valid data.
- `out_ready`  in  1  consumer accepts.
- `out_src`  out  1  bank currently presented; equals `sel`.

## Operation
- States: IDLE, SETTLE, PRESENT.
- Reset values: state IDLE, `sel`=0, `out_valid`=0, `req_ready`=0, burst count 0, settle count 0. Reset mid-SETTLE or mid-PRESENT aborts immediately; no transfer strobe is issued.
- Arbitration runs in IDLE and at every PRESENT exit point. "Cur" = `sel`, "oth" = !`sel`.
  - If `req_valid[cur]` is set and (burst < `HOLD_MAX` or !`req_valid[oth]`): stay on cur.
  - Else if `req_valid[oth]`: switch. Toggle `sel`, clear burst, enter SETTLE (go to PRESENT if `SETTLE_CYC`=0).
  - Else: IDLE.
- IDLE: winner on cur goes to PRESENT; winner on oth switches. When both banks are valid, cur wins, which avoids a settle penalty.
- SETTLE: counter loads `SETTLE_CYC`-1 and decrements. At 0, go to PRESENT. `req_valid` is ignored here.
- PRESENT: `out_valid` = `req_valid[sel]`. Transfer = `out_valid` && `out_ready`. Transfer asserts `req_ready[sel]` in the same cycle and increments burst (saturating at `HOLD_MAX`).
  - On a transfer, re-arbitrate.
  - If `req_valid[sel]` drops without a transfer (protocol violation), re-arbitrate the same way.
- Burst width: $clog2(`HOLD_MAX`+1).
- Settle counter width: $clog2(`SETTLE_CYC`+1), minimum 1.

## Timing
- `out_valid` and `req_ready` are combinational from registered state, `req_valid`, and `out_ready`. `sel` and state are registered.
- Request on cur in IDLE at cycle N: `out_valid` at N+1.
- Request needing a switch at cycle N: `sel` toggles at N+1, SETTLE covers N+1..N+`SETTLE_CYC`, `out_valid` rises at N+1+`SETTLE_CYC`.
- Back-to-back transfers on the same bank: no bubble. A transfer at M is followed by `out_valid` at M+1 if the bank is still valid.
- Switch after a transfer at M: same timing as the switch case above, with M in place of N.
- `sel` never changes while `out_valid`=1.
- `req_ready` is never asserted outside PRESENT, and never for both bits.

## Configuration
- `MUX16TO8_CTRL_STATS_EN` defined: adds two outputs.
  - `stat_xfers[15:0]`: counts transfers.
  - `stat_switches[15:0]`: counts `sel` toggles.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and counters are absent. Functional behaviour is identical in both cases.

## Structure
- Package `mux_ctrl_pkg` holds:
  - the state enum typedef `mux_ctrl_state_t` (IDLE, SETTLE, PRESENT);
  - constants `SEL_BANK0`=1'b0 and `SEL_BANK1`=1'b1;
  - the stats counter width constant (16).
- Sub-module `mux_settle_timer` covers load, decrement and done. It is parameterised by `SETTLE_CYC` and handles the 0 case by asserting done on load.

## Test plan
- Reset, then `req_valid`=01 at cycle 1 with `out_ready`=1 → `sel` stays 0, `out_valid`=1 at cycle 2, `req_ready`=01 at cycle 2.
- `req_valid`=10 from IDLE with `sel`=0 and `SETTLE_CYC`=2 → `sel`=1 at N+1, `out_valid`=0 for N+1..N+2, `out_valid`=1 at N+3.
- Both banks held valid, `out_ready`=1, `HOLD_MAX`=4 → pattern of 4 bank-0 transfers, 2 settle cycles, 4 bank-1 transfers, repeating. `sel` never toggles while `out_valid`=1.
- `out_ready`=0 for 5 cycles in PRESENT → `out_valid` held at 1, `sel` stable, no `req_ready`. Releasing `out_ready` gives exactly one strobe.
- `rst` asserted during SETTLE → next cycle `sel`=0, IDLE, `out_valid`=0, no `req_ready` pulse.
- `SETTLE_CYC`=0 with `MUX16TO8_CTRL_STATS_EN` defined: alternating single requests → `out_valid` one cycle after each switch request; after 6 transfers, `stat_xfers`=6 and `stat_switches` matches the toggle count.
